// File: rtl/muldiv_if.sv
// muldiv_if: handshake and operand bus between an issuing stage and the
// muldiv_unit execution unit.
//   start_i   launch request (sampled by the unit only while idle)
//   abort_i   cancel the operation in flight
//   funct3_i  RV32M funct3 operation code
//   op_a_i    rs1 value (multiplicand / dividend)
//   op_b_i    rs2 value (multiplier / divisor)
//   busy_o    unit is computing
//   done_o    one-cycle completion pulse, result_o valid alongside it
//   result_o  registered result, held until the next completion
interface muldiv_if #(
  parameter int BITNESS = 32
);
  logic               start_i;
  logic               abort_i;
  logic [2:0]         funct3_i;
  logic [BITNESS-1:0] op_a_i;
  logic [BITNESS-1:0] op_b_i;
  logic               busy_o;
  logic               done_o;
  logic [BITNESS-1:0] result_o;

  modport master (
    output start_i, abort_i, funct3_i, op_a_i, op_b_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, abort_i, funct3_i, op_a_i, op_b_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit. Radix-2 shift-add
// multiply and restoring divide on operand magnitudes, one bit per cycle,
// with sign correction in a final cycle. Divide-by-zero and signed
// division overflow bypass the iteration entirely.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  asynchronous active-high reset
//   bus    muldiv_if slave: start/abort/funct3/operands in, busy/done/result out
module muldiv_unit #(
  parameter int BITNESS = 32
) (
  input  logic     clk_i,
  input  logic     rst_i,
  muldiv_if.slave  bus
);

  localparam int W  = BITNESS;
  localparam int W2 = 2 * BITNESS;
  localparam int CW = $clog2(BITNESS + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  // Magnitude of a value that may be interpreted as two's complement.
  // The most negative value maps onto itself, which is its correct
  // unsigned magnitude.
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v,
                                             input logic is_signed);
    logic [W-1:0] m;
    if (is_signed && v[W-1]) begin
      m = ~v + W'(1);
    end else begin
      m = v;
    end
    return m;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    funct3_q, funct3_d;
  logic          neg_q, neg_d;         // final result must be negated
  logic          special_q, special_d; // fast-path result sits in lo_q
  logic [W-1:0]  opnd_q, opnd_d;       // multiplicand or divisor magnitude
  logic [W-1:0]  hi_q, hi_d;           // product high half / partial remainder
  logic [W-1:0]  lo_q, lo_d;           // multiplier bits / quotient bits
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  result_q, result_d;

  // Launch decode of the operation presented on the bus.
  logic         is_div_s, a_signed_s, b_signed_s, sign_a_s, sign_b_s;
  logic         dzero_s, ovf_s, start_neg_s;
  logic [W-1:0] mag_a_s, mag_b_s, special_res_s;

  // Decode signedness, result sign and the fast-path cases at launch.
  always_comb begin
    is_div_s = bus.funct3_i[2];
    if (is_div_s) begin
      a_signed_s = ~bus.funct3_i[0];
      b_signed_s = ~bus.funct3_i[0];
    end else begin
      a_signed_s = (bus.funct3_i[1:0] != 2'b11);
      b_signed_s = ~bus.funct3_i[1];
    end
    sign_a_s = a_signed_s & bus.op_a_i[W-1];
    sign_b_s = b_signed_s & bus.op_b_i[W-1];
    // A remainder follows the dividend; products and quotients follow the sign mix.
    if (is_div_s && bus.funct3_i[1]) begin
      start_neg_s = sign_a_s;
    end else begin
      start_neg_s = sign_a_s ^ sign_b_s;
    end
    mag_a_s = magnitude(bus.op_a_i, a_signed_s);
    mag_b_s = magnitude(bus.op_b_i, b_signed_s);
    dzero_s = is_div_s && (bus.op_b_i == {W{1'b0}});
    ovf_s   = is_div_s && ~bus.funct3_i[0] &&
              (bus.op_a_i == {1'b1, {(W-1){1'b0}}}) &&
              (bus.op_b_i == {W{1'b1}});
    if (dzero_s) begin
      special_res_s = bus.funct3_i[1] ? bus.op_a_i : {W{1'b1}};
    end else begin
      special_res_s = bus.funct3_i[1] ? {W{1'b0}} : bus.op_a_i;
    end
  end

  // One radix-2 iteration of each datapath.
  logic [W:0]   mul_sum_s, mul_step_s;
  logic [W:0]   rem_shift_s, div_diff_s;
  logic         div_ge_s;
  logic [W-1:0] mul_hi_s, mul_lo_s, div_hi_s, div_lo_s;

  // Shift-add step for multiply and shift-subtract step for divide.
  always_comb begin
    mul_sum_s = {1'b0, hi_q} + {1'b0, opnd_q};
    if (lo_q[0]) begin
      mul_step_s = mul_sum_s;
    end else begin
      mul_step_s = {1'b0, hi_q};
    end
    // The carry out of the add shifts into the top of the high half.
    mul_hi_s = mul_step_s[W:1];
    mul_lo_s = {mul_step_s[0], lo_q[W-1:1]};

    rem_shift_s = {hi_q, lo_q[W-1]};
    // Partial remainder stays below 2*divisor, so bit W is a clean borrow.
    div_diff_s  = rem_shift_s - {1'b0, opnd_q};
    div_ge_s    = ~div_diff_s[W];
    if (div_ge_s) begin
      div_hi_s = div_diff_s[W-1:0];
    end else begin
      div_hi_s = rem_shift_s[W-1:0];
    end
    div_lo_s = {lo_q[W-2:0], div_ge_s};
  end

  // Sign correction and result selection used in FINISH.
  logic [W2-1:0] prod_s;
  logic [W-1:0]  quot_s, rem_s, fin_res_s;

  // Apply the recorded sign and pick the half or quotient/remainder.
  always_comb begin
    if (neg_q) begin
      prod_s = ~{hi_q, lo_q} + W2'(1);
      quot_s = ~lo_q + W'(1);
      rem_s  = ~hi_q + W'(1);
    end else begin
      prod_s = {hi_q, lo_q};
      quot_s = lo_q;
      rem_s  = hi_q;
    end
    if (special_q) begin
      fin_res_s = lo_q;
    end else begin
      case (funct3_q)
        3'b000:                 fin_res_s = prod_s[W-1:0];
        3'b001, 3'b010, 3'b011: fin_res_s = prod_s[W2-1:W];
        3'b100, 3'b101:         fin_res_s = quot_s;
        3'b110, 3'b111:         fin_res_s = rem_s;
        default:                fin_res_s = {W{1'b0}};
      endcase
    end
  end

  // Next-state logic for the control FSM, datapath and registered outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    funct3_d  = funct3_q;
    neg_d     = neg_q;
    special_d = special_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          funct3_d = bus.funct3_i;
          busy_d   = 1'b1;
          hi_d     = {W{1'b0}};
          if (dzero_s || ovf_s) begin
            special_d = 1'b1;
            neg_d     = 1'b0;
            lo_d      = special_res_s;
            state_d   = S_FINISH;
          end else begin
            special_d = 1'b0;
            neg_d     = start_neg_s;
            cnt_d     = CW'(W);
            state_d   = S_CALC;
            // Divide shifts the dividend out of lo; multiply shifts the multiplier out.
            if (is_div_s) begin
              lo_d   = mag_a_s;
              opnd_d = mag_b_s;
            end else begin
              lo_d   = mag_b_s;
              opnd_d = mag_a_s;
            end
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      S_CALC: begin
        if (bus.abort_i) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (funct3_q[2]) begin
            hi_d = div_hi_s;
            lo_d = div_lo_s;
          end else begin
            hi_d = mul_hi_s;
            lo_d = mul_lo_s;
          end
          if (cnt_q == CW'(1)) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (bus.abort_i) begin
          done_d = 1'b0;
        end else begin
          done_d   = 1'b1;
          result_d = fin_res_s;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      funct3_q  <= 3'b000;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      opnd_q    <= {W{1'b0}};
      hi_q      <= {W{1'b0}};
      lo_q      <= {W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= {W{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      funct3_q  <= funct3_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand-written
// control sequences (abort, reset, held start, back-to-back), randomized
// operations against an arithmetic reference model, and a BITNESS=8 instance.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if #(.BITNESS(32)) bus32();
  muldiv_if #(.BITNESS(8))  bus8();

  muldiv_unit #(.BITNESS(32)) dut32 (.clk_i(clk), .rst_i(rst), .bus(bus32));
  muldiv_unit #(.BITNESS(8))  dut8  (.clk_i(clk), .rst_i(rst), .bus(bus8));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model from the instruction semantics, using 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b, output int lat);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    lat = 33;
    p   = 64'd0;
    case (f)
      3'd0: begin p = 64'(sa * sb); r = p[31:0];  end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) begin lat = 1; r = 32'hFFFF_FFFF; end
        else if (ovf) begin lat = 1; r = a; end
        else r = 32'(sa / sb);
      end
      3'd5: begin
        if (b == 32'd0) begin lat = 1; r = 32'hFFFF_FFFF; end
        else r = 32'(ua / ub);
      end
      3'd6: begin
        if (b == 32'd0) begin lat = 1; r = a; end
        else if (ovf) begin lat = 1; r = 32'd0; end
        else r = 32'(sa % sb);
      end
      default: begin
        if (b == 32'd0) begin lat = 1; r = a; end
        else r = 32'(ua % ub);
      end
    endcase
    return r;
  endfunction

  // Present an operation for exactly one edge (E0), then scramble operands.
  task automatic start32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bus32.start_i  = 1'b1;
    bus32.funct3_i = f;
    bus32.op_a_i   = a;
    bus32.op_b_i   = b;
    @(posedge clk); #1;
    bus32.start_i  = 1'b0;
    bus32.funct3_i = 3'($urandom_range(0, 7));
    bus32.op_a_i   = $urandom;
    bus32.op_b_i   = $urandom;
  endtask

  // Called #1 after E0; returns #1 after the edge that raised done_o.
  task automatic wait32(output logic [31:0] res, output int lat, output bit busy_ok);
    lat = 0; busy_ok = 1'b1; res = 32'd0;
    for (int k = 1; k <= 60; k++) begin
      if (bus32.busy_o !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      if (bus32.done_o === 1'b1) begin
        lat = k;
        res = bus32.result_o;
        if (bus32.busy_o !== 1'b0) busy_ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic run32(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    int lat;
    bit busy_ok;
    start32(f, a, b);
    wait32(res, lat, busy_ok);
    check32({name, " result"}, res, exp);
    check_int({name, " latency"}, lat, exp_lat);
    check_int({name, " busy"}, int'(busy_ok), 1);
    @(posedge clk); #1;
    check_int({name, " done pulse"}, int'(bus32.done_o), 0);
  endtask

  initial begin
    logic [31:0] res, exp, prior;
    int lat, exp_lat;
    bit busy_ok, seen;
    logic [2:0] f;
    logic [31:0] a, b;

    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vecs[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[3]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        33};
    vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         33};
    vecs[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd7, 32'd5,         32'd0,         32'd5,         1};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
    vecs[12] = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[13] = '{3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1};
    vecs[14] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33};
    vecs[15] = '{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
    vecs[16] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    vecs[17] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         33};

    rst = 1'b1;
    bus32.start_i = 1'b0; bus32.abort_i = 1'b0; bus32.funct3_i = 3'd0;
    bus32.op_a_i = 32'd0; bus32.op_b_i = 32'd0;
    bus8.start_i = 1'b0; bus8.abort_i = 1'b0; bus8.funct3_i = 3'd0;
    bus8.op_a_i = 8'd0; bus8.op_b_i = 8'd0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    check_int("reset busy", int'(bus32.busy_o), 0);
    check_int("reset done", int'(bus32.done_o), 0);
    check32("reset result", bus32.result_o, 32'd0);
    check_int("reset8 busy", int'(bus8.busy_o), 0);
    check32("reset8 result", {24'd0, bus8.result_o}, 32'd0);

    // Directed vector table.
    for (int i = 0; i < 18; i++) begin
      run32($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    // start_i held high through CALC with different operands: ignored.
    bus32.start_i = 1'b1; bus32.funct3_i = 3'd5; bus32.op_a_i = 32'd100; bus32.op_b_i = 32'd7;
    @(posedge clk); #1;
    bus32.funct3_i = 3'd0; bus32.op_a_i = 32'd3; bus32.op_b_i = 32'd3;
    lat = 0; res = 32'd0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == 20) bus32.start_i = 1'b0;
      if (bus32.done_o === 1'b1) begin lat = k; res = bus32.result_o; break; end
    end
    check32("held start result", res, 32'd14);
    check_int("held start latency", lat, 33);

    // Establish a prior result, then abort at iteration 10.
    run32("pre-abort", 3'd0, 32'd3, 32'd5, 32'd15, 33);
    start32(3'd5, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    bus32.abort_i = 1'b1; bus32.start_i = 1'b1; bus32.funct3_i = 3'd0;
    bus32.op_a_i = 32'd9; bus32.op_b_i = 32'd9;
    @(posedge clk); #1;
    bus32.abort_i = 1'b0; bus32.start_i = 1'b0;
    check_int("abort busy", int'(bus32.busy_o), 0);
    check_int("abort done", int'(bus32.done_o), 0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus32.done_o === 1'b1 || bus32.busy_o === 1'b1) seen = 1'b1;
    end
    check_int("abort no activity", int'(seen), 0);
    check32("abort result kept", bus32.result_o, 32'd15);

    // abort_i in IDLE has no effect on a launch.
    bus32.abort_i = 1'b1;
    start32(3'd0, 32'd2, 32'd3);
    bus32.abort_i = 1'b0;
    wait32(res, lat, busy_ok);
    check32("idle abort result", res, 32'd6);
    check_int("idle abort latency", lat, 33);

    // Asynchronous reset mid-CALC.
    @(posedge clk); #1;
    start32(3'd3, 32'hFFFF_FFFF, 32'h1234_5678);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_int("async rst busy", int'(bus32.busy_o), 0);
    check_int("async rst done", int'(bus32.done_o), 0);
    check32("async rst result", bus32.result_o, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus32.done_o === 1'b1) seen = 1'b1;
    end
    check_int("rst no done", int'(seen), 0);

    // Back-to-back: start in the done_o cycle.
    start32(3'd0, 32'h0000_0007, 32'hFFFF_FFFD);
    wait32(res, lat, busy_ok);
    check32("b2b first result", res, 32'hFFFF_FFEB);
    start32(3'd5, 32'd100, 32'd7);
    wait32(res, lat, busy_ok);
    check32("b2b second result", res, 32'd14);
    check_int("b2b second latency", lat, 33);
    check_int("b2b second busy", int'(busy_ok), 1);
    @(posedge clk); #1;

    // Randomized operations against the reference model.
    for (int n = 0; n < 80; n++) begin
      f = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      exp = model(f, a, b, exp_lat);
      start32(f, a, b);
      wait32(res, lat, busy_ok);
      check32($sformatf("rand%0d f=%0d a=%h b=%h result", n, f, a, b), res, exp);
      check_int($sformatf("rand%0d latency", n), lat, exp_lat);
    end

    // BITNESS=8 instance: MULHU 0xFF*0xFF, then DIV overflow fast path.
    bus8.start_i = 1'b1; bus8.funct3_i = 3'd3; bus8.op_a_i = 8'hFF; bus8.op_b_i = 8'hFF;
    @(posedge clk); #1;
    bus8.start_i = 1'b0;
    lat = 0; res = 32'd0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (bus8.done_o === 1'b1) begin lat = k; res = {24'd0, bus8.result_o}; break; end
    end
    check32("w8 mulhu result", res, 32'h0000_00FE);
    check_int("w8 mulhu latency", lat, 9);
    bus8.start_i = 1'b1; bus8.funct3_i = 3'd4; bus8.op_a_i = 8'h80; bus8.op_b_i = 8'hFF;
    @(posedge clk); #1;
    bus8.start_i = 1'b0;
    lat = 0; res = 32'd0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (bus8.done_o === 1'b1) begin lat = k; res = {24'd0, bus8.result_o}; break; end
    end
    check32("w8 div ovf result", res, 32'h0000_0080);
    check_int("w8 div ovf latency", lat, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
